// File: rtl/vigenere_sel_gen_if.sv
// Key-entry, text-input and select-output handshake bundle for vigenere_sel_gen.
// The master side drives key/text/sel_ready; the slave side (the block) drives the select word.
interface vigenere_sel_gen_if;
  logic       key_load;
  logic [7:0] key_char;
  logic       key_last;
  logic       mode;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic [7:0] sel;
  logic       sel_alpha;
  logic       sel_upper;
  logic [7:0] sel_char;
  logic       sel_valid;
  logic       sel_ready;

  modport master (
    output key_load, key_char, key_last, mode, in_valid, in_char, sel_ready,
    input  in_ready, sel, sel_alpha, sel_upper, sel_char, sel_valid
  );

  modport slave (
    input  key_load, key_char, key_last, mode, in_valid, in_char, sel_ready,
    output in_ready, sel, sel_alpha, sel_upper, sel_char, sel_valid
  );
endinterface

// File: rtl/vigenere_sel_gen.sv
// Vigenere shift generator: stores a letter key, then turns each text character into a
// 0..25 letter index for a downstream 26:1 select, one character per cycle.
module vigenere_sel_gen #(
  parameter int KEY_MAX = 16
) (
  input logic              clk,
  input logic              rst,
  vigenere_sel_gen_if.slave bus
);

  localparam int KW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam int LW = $clog2(KEY_MAX + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state;
  state_t        state_next;
  logic [4:0]    key_mem [0:(1<<KW)-1];
  logic [LW-1:0] key_len;
  logic [KW-1:0] kpos;

  logic [7:0]    sel_q;
  logic          sel_alpha_q;
  logic          sel_upper_q;
  logic [7:0]    sel_char_q;
  logic          sel_valid_q;

  logic          in_ready_c;
  logic          in_xfer;
  logic          out_xfer;

  logic          key_is_upper;
  logic          key_is_letter;
  logic [4:0]    key_idx;
  logic [LW-1:0] base_len;
  logic          store_key;
  logic [LW-1:0] new_len;

  logic          in_is_upper;
  logic          in_is_letter;
  logic [4:0]    in_idx;
  logic [4:0]    key_val;
  logic [5:0]    sum6;
  logic [5:0]    enc6;
  logic [5:0]    dec6;
  logic [4:0]    shifted;
  logic [LW-1:0] kpos_inc;
  logic [KW-1:0] kpos_wrap;

  // Key character decode; a strobe that enters LOAD starts a fresh key at length 0.
  always_comb begin
    key_is_upper  = (bus.key_char >= 8'h41) && (bus.key_char <= 8'h5a);
    key_is_letter = key_is_upper ||
                    ((bus.key_char >= 8'h61) && (bus.key_char <= 8'h7a));
    key_idx       = key_is_upper ? 5'(bus.key_char - 8'h41) : 5'(bus.key_char - 8'h61);
    base_len      = (state == LOAD) ? key_len : '0;
    store_key     = bus.key_load && key_is_letter && (base_len < LW'(KEY_MAX));
    new_len       = base_len + LW'(store_key);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.key_load) begin
      if (bus.key_last) state_next = (new_len != '0) ? RUN : IDLE;
      else              state_next = LOAD;
    end
  end

  always_comb begin
    in_ready_c = (state == RUN) && !bus.key_load && (!sel_valid_q || bus.sel_ready);
    in_xfer    = bus.in_valid && in_ready_c;
    out_xfer   = sel_valid_q && bus.sel_ready;
  end

  // Text decode and modular shift; decrypt adds 26 before subtracting to stay non-negative.
  always_comb begin
    in_is_upper  = (bus.in_char >= 8'h41) && (bus.in_char <= 8'h5a);
    in_is_letter = in_is_upper ||
                   ((bus.in_char >= 8'h61) && (bus.in_char <= 8'h7a));
    in_idx       = in_is_upper ? 5'(bus.in_char - 8'h41) : 5'(bus.in_char - 8'h61);
    key_val      = key_mem[kpos];
    sum6         = {1'b0, in_idx} + {1'b0, key_val};
    enc6         = (sum6 >= 6'd26) ? (sum6 - 6'd26) : sum6;
    dec6         = (in_idx >= key_val) ? ({1'b0, in_idx} - {1'b0, key_val})
                                       : ({1'b0, in_idx} + 6'd26 - {1'b0, key_val});
    shifted      = bus.mode ? 5'(dec6) : 5'(enc6);
    kpos_inc     = LW'(kpos) + LW'(1);
    kpos_wrap    = (kpos_inc >= key_len) ? '0 : KW'(kpos_inc);
  end

  always_ff @(posedge clk) begin
    if (store_key) key_mem[KW'(base_len)] <= key_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_len <= '0;
      kpos    <= '0;
    end else if (bus.key_load) begin
      key_len <= new_len;
      kpos    <= '0;
    end else if (in_xfer && in_is_letter) begin
      kpos    <= kpos_wrap;
    end
  end

  // Output word register: loads on every accepted char, holds under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q       <= 8'h00;
      sel_alpha_q <= 1'b0;
      sel_upper_q <= 1'b0;
      sel_char_q  <= 8'h00;
      sel_valid_q <= 1'b0;
    end else if (in_xfer) begin
      sel_q       <= in_is_letter ? {3'b000, shifted} : 8'h00;
      sel_alpha_q <= in_is_letter;
      sel_upper_q <= in_is_upper;
      sel_char_q  <= bus.in_char;
      sel_valid_q <= 1'b1;
    end else if (out_xfer) begin
      sel_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.sel       = sel_q;
  assign bus.sel_alpha = sel_alpha_q;
  assign bus.sel_upper = sel_upper_q;
  assign bus.sel_char  = sel_char_q;
  assign bus.sel_valid = sel_valid_q;

endmodule

// File: doc/vigenere_sel_gen.md
VIGENERE_SEL_GEN -- requirements
Module: vigenere_sel_gen

Interface
REQ-001 Parameter KEY_MAX, default 16: maximum stored key letters (2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 key_load  input  1  key_char valid this cycle (key entry strobe).
REQ-005 key_char  input  8  ASCII key character.
REQ-006 key_last  input  1  with key_load: final key character.
REQ-007 mode  input  1  0 = encrypt (add shift), 1 = decrypt (subtract shift); sampled per accepted char.
REQ-008 in_valid  input  1  in_char valid.
REQ-009 in_char  input  8  ASCII text character.
REQ-010 in_ready  output  1  block accepts in_char this cycle.
REQ-011 sel  output  8  letter index 0..25 for the downstream 26:1 select; upper bits always 0.
REQ-012 sel_alpha  output  1  1 = sel is valid letter index; 0 = non-letter passthrough.
REQ-013 sel_upper  output  1  1 = source letter was upper case.
REQ-014 sel_char  output  8  original in_char, registered with sel.
REQ-015 sel_valid  output  1  output word valid.
REQ-016 sel_ready  input  1  downstream accepts output word.

Function
REQ-017 FSM states: IDLE (no key), LOAD (key entry), RUN (text processing).
REQ-018 IDLE -> LOAD on key_load; RUN -> LOAD on key_load; in LOAD, key_load with key_last -> RUN if >=1 letter stored (including this char), else IDLE.
REQ-019 Key letter index: 'A'..'Z' -> 0..25, 'a'..'z' -> 0..25; other key_char values discarded, not stored.
REQ-020 Letters beyond KEY_MAX discarded; key_len saturates at KEY_MAX.
REQ-021 Entering LOAD clears key_len and key position kpos to 0; previous key discarded.
REQ-022 in_ready = 1 only in RUN with key_load = 0 and (sel_valid = 0 or sel_ready = 1).
REQ-023 Transfer in: in_valid & in_ready; transfer out: sel_valid & sel_ready.
REQ-024 Latency: accepted char appears on outputs, sel_valid = 1, the next cycle; full throughput of one char per cycle with sel_ready held 1.
REQ-025 Output word held stable while sel_valid = 1 and sel_ready = 0.
REQ-026 sel_valid clears after an out transfer with no simultaneous in transfer.
REQ-027 Encrypt: sel = (idx + key[kpos]) mod 26; decrypt: sel = (idx - key[kpos]) mod 26, result always 0..25.
REQ-028 Non-letter in_char: sel = 0, sel_alpha = 0, sel_upper = 0, kpos unchanged.
REQ-029 Letter accepted: kpos increments, wrapping to 0 after key_len-1.
REQ-030 key_load and in_valid in same cycle: key_load wins; in_char not accepted.
REQ-031 A pending output word still drains during LOAD; no new input is accepted until RUN.
REQ-032 No input is accepted in IDLE or LOAD; in_valid there is ignored.

Reset
REQ-033 rst asserted, at any time including mid-stream: state = IDLE, key_len = 0, kpos = 0, sel = 0, sel_alpha = 0, sel_upper = 0, sel_char = 0, sel_valid = 0, in_ready = 0 immediately, without waiting for a clock edge.
REQ-034 After reset a key is reloaded before text processing; a pending output word is lost.

Verification
REQ-035 Load key "KEY", encrypt "HELLO", sel_ready = 1 -> sel 17, 8, 9, 21, 18, one per cycle, sel_upper = 1.
REQ-036 Key "KEY", mode = 1, input "RIJVS" -> sel 7, 4, 11, 11, 14.
REQ-037 Key "B", encrypt "a z" -> sel 1 (upper 0); space with sel_alpha = 0 and sel_char = 0x20; then sel 0 (wrap 25 -> 0); kpos not advanced by the space.
REQ-038 Hold sel_ready = 0 for 3 cycles with in_valid = 1 -> output frozen, in_ready = 0, no char lost or duplicated after release.
REQ-039 Load 17 letters "BBBBBBBBBBBBBBBBC" with KEY_MAX = 16 -> key_len = 16, 'C' discarded; key "1!" (no letters) with key_last -> return to IDLE, in_ready stays 0.
REQ-040 Assert rst mid-stream with sel_valid = 1 -> all outputs 0 asynchronously; the subsequent key load and stream give correct results from kpos = 0.
